genius_control_fsm: RTL and testbench
=====================================

Name: genius_control_fsm

Overview:
- Control unit for the memory-game datapath.
- Consumes the datapath status flags end_FPGA, end_User, end_time, win and match.
- Drives the datapath resets (R1, R2), enables (E1–E4) and the display select (SEL).
- Sequences the game: setup, FPGA sequence playback, user entry, compare, round advance, result display.

Parameters:
- P_HOLD_CYCLES, 500_000_000: cycles RESULT waits before auto-returning to INIT (10 s at 50 MHz); 0 disables auto-return.
- P_HOLD_W, 32: width of the hold counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- enter  in  1  synchronized confirm button, active-high level
- end_FPGA  in  1  FPGA sequence playback finished
- end_User  in  1  user has entered ROUND symbols
- end_time  in  1  user time limit expired
- win  in  1  final round reached
- match  in  1  REG_FPGA equals REG_User
- R1  out  1  game-level reset: setup, round, clock divider
- R2  out  1  round-level reset: timer, FPGA/user counters, shift registers
- E1  out  1  load setup register
- E2  out  1  enable user timer/entry
- E3  out  1  enable FPGA sequence counter/register
- E4  out  1  increment round counter
- SEL  out  1  1 = status display (L/level/t/time/r/round); 0 = message + points
- state_o  out  3  current state, for debug LEDs

Behaviour:
- State encoding (3 bits):
  - INIT=0, SETUP=1, SEQ=2, PLAY=3, CHECK=4, NEXT=5, REPLAY=6, RESULT=7
  - Unused codes: none.
- Reset: async; state=INIT, outputs R1=1, R2=1, E1..E4=0, SEL=1, enter_q=0, hold_cnt=0, retry_used=0.
- Outputs are registered Moore decodes of next state, so they are valid in the same cycle state holds that value.
- Output decode per state:
  - INIT: R1=1, R2=1
  - SETUP: E1=1
  - SEQ: E3=1
  - PLAY: E2=1
  - CHECK: none
  - NEXT: E4=1, R2=1
  - REPLAY: R2=1
  - RESULT: SEL=0
  - SEL=1 in every state except RESULT.
- enter_pulse = enter & ~enter_q; enter_q is registered each cycle. Holding enter yields exactly one pulse.
- State transitions:
  - INIT -> SETUP, unconditionally after 1 cycle.
  - SETUP -> SEQ on enter_pulse.
  - SEQ -> PLAY when end_FPGA=1.
  - PLAY:
    - end_time=1 -> RESULT (lose). end_time has priority over a simultaneous end_User.
    - else end_User=1 -> CHECK.
  - CHECK, evaluated 1 cycle after end_User so match has settled:
    - match & win -> RESULT (win)
    - match & ~win -> NEXT
    - ~match -> RESULT, or REPLAY (see Optional Feature)
  - NEXT -> SEQ after 1 cycle.
  - REPLAY -> SEQ after 1 cycle.
  - RESULT:
    - enter_pulse -> INIT.
    - If P_HOLD_CYCLES != 0, hold_cnt counts up from 0 on entry; at P_HOLD_CYCLES-1 -> INIT.
    - enter_pulse in the same cycle as expiry -> INIT (identical result).
    - hold_cnt clears whenever state != RESULT.
- enter_pulse is ignored in every state except SETUP and RESULT.
- Any status flag is ignored outside the state that samples it.
- Reset asserted mid-game: immediate return to INIT outputs; no partial round survives.

Optional Feature:
- Macro: GENIUS_RETRY_EN.
- Defined:
  - CHECK with ~match and retry_used=0 -> REPLAY, and sets retry_used.
  - PLAY timeout with retry_used=0 also -> REPLAY.
  - retry_used clears in NEXT and INIT.
  - A second failure in the same round -> RESULT.
- Not defined:
  - REPLAY is unreachable; retry_used logic is removed.
  - Failures always go -> RESULT.

Decomposition:
- Shared package genius_pkg:
  - state localparams ST_INIT..ST_RESULT
  - state width constant (3)
  - the datapath parameter set (p_key, p_switch, p_hex, p_led), so datapath and controller agree.
- One sub-module, genius_edge_det (rising-edge pulse generator with async reset), reused for enter; other logic stays flat.

Test Plan:
- Reset then release; hold enter=0 for 5 cycles -> state_o 0 then 1; R1=R2=1 only in the INIT cycle; E1=1 and SEL=1 in SETUP.
- enter held high 10 cycles in SETUP -> exactly one transition to SEQ (state_o=2) and E3=1.
- SEQ: end_FPGA=1 -> PLAY with E2=1. PLAY: end_User=1 -> CHECK. CHECK: match=1, win=0 -> NEXT, one cycle with E4=1 and R2=1, then SEQ.
- PLAY with end_time=1 and end_User=1 in the same cycle -> RESULT (state_o=7), SEL=0; no CHECK visited.
- CHECK with match=1, win=1 -> RESULT. With P_HOLD_CYCLES=20 and no enter -> INIT after exactly 20 RESULT cycles.
- With GENIUS_RETRY_EN: first mismatch -> REPLAY (R2=1), then SEQ. Second mismatch in the same round -> RESULT. After a NEXT, a mismatch -> REPLAY again.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared constants for the memory-game controller and its datapath:
// state codes, control-word layout and the board-level datapath widths.
package genius_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_INIT   = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP  = 3'd1;
  localparam logic [ST_W-1:0] ST_SEQ    = 3'd2;
  localparam logic [ST_W-1:0] ST_PLAY   = 3'd3;
  localparam logic [ST_W-1:0] ST_CHECK  = 3'd4;
  localparam logic [ST_W-1:0] ST_NEXT   = 3'd5;
  localparam logic [ST_W-1:0] ST_REPLAY = 3'd6;
  localparam logic [ST_W-1:0] ST_RESULT = 3'd7;

  // Datapath parameter set, shared so the datapath and controller agree.
  localparam int p_key    = 4;
  localparam int p_switch = 10;
  localparam int p_hex    = 6;
  localparam int p_led    = 10;

  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } ctrl_t;

  // Moore decode of the datapath control word for a given state.
  function automatic ctrl_t ctrl_decode(input logic [ST_W-1:0] st);
    ctrl_t c;
    c     = '0;
    c.sel = 1'b1;
    case (st)
      ST_INIT:   begin c.r1 = 1'b1; c.r2 = 1'b1; end
      ST_SETUP:  c.e1 = 1'b1;
      ST_SEQ:    c.e3 = 1'b1;
      ST_PLAY:   c.e2 = 1'b1;
      ST_CHECK:  ;
      ST_NEXT:   begin c.e4 = 1'b1; c.r2 = 1'b1; end
      ST_REPLAY: c.r2 = 1'b1;
      ST_RESULT: c.sel = 1'b0;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/genius_edge_det.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of d_i.
module genius_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/genius_control_fsm.sv
// Memory-game control FSM driving datapath resets/enables and display select.
// Optional retry-once-per-round behaviour is enabled by defining GENIUS_RETRY_EN.
module genius_control_fsm
  import genius_pkg::*;
#(
  parameter int unsigned P_HOLD_CYCLES = 500_000_000,
  parameter int          P_HOLD_W      = 32
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            enter,
  input  logic            end_FPGA,
  input  logic            end_User,
  input  logic            end_time,
  input  logic            win,
  input  logic            match,
  output logic            R1,
  output logic            R2,
  output logic            E1,
  output logic            E2,
  output logic            E3,
  output logic            E4,
  output logic            SEL,
  output logic [ST_W-1:0] state_o
);

  localparam ctrl_t CTRL_RESET = ctrl_decode(ST_INIT);

  logic [ST_W-1:0] state_q, state_d;
  logic [ST_W-1:0] fail_state;
  ctrl_t           ctrl_q, ctrl_d;
  logic            enter_pulse;
  logic            hold_expired;

  genius_edge_det u_enter_edge (
    .clk     (CLOCK_50),
    .rst     (reset),
    .d_i     (enter),
    .pulse_o (enter_pulse)
  );

  // RESULT auto-return timer; counts only while RESULT is held.
  generate
    if (P_HOLD_CYCLES != 0) begin : g_hold
      localparam logic [P_HOLD_W-1:0] HOLD_LAST = P_HOLD_W'(P_HOLD_CYCLES - 1);
      logic [P_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

      always_comb begin
        hold_cnt_d = '0;
        if (state_q == ST_RESULT && state_d == ST_RESULT)
          hold_cnt_d = hold_cnt_q + 1'b1;
      end

      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) hold_cnt_q <= '0;
        else       hold_cnt_q <= hold_cnt_d;
      end

      assign hold_expired = (state_q == ST_RESULT) && (hold_cnt_q == HOLD_LAST);
    end else begin : g_no_hold
      assign hold_expired = 1'b0;
    end
  endgenerate

`ifdef GENIUS_RETRY_EN
  logic retry_used_q, retry_used_d;

  assign fail_state = retry_used_q ? ST_RESULT : ST_REPLAY;

  always_comb begin
    retry_used_d = retry_used_q;
    if (state_d == ST_NEXT || state_d == ST_INIT)
      retry_used_d = 1'b0;
    else if (state_d == ST_REPLAY)
      retry_used_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) retry_used_q <= 1'b0;
    else       retry_used_q <= retry_used_d;
  end
`else
  assign fail_state = ST_RESULT;
`endif

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next-state logic; each flag only matters in the state that samples it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_SETUP;
      ST_SETUP:  if (enter_pulse) state_d = ST_SEQ;
      ST_SEQ:    if (end_FPGA) state_d = ST_PLAY;
      ST_PLAY: begin
        if (end_time)      state_d = fail_state;
        else if (end_User) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (match) state_d = win ? ST_RESULT : ST_NEXT;
        else       state_d = fail_state;
      end
      ST_NEXT:   state_d = ST_SEQ;
      ST_REPLAY: state_d = ST_SEQ;
      ST_RESULT: if (enter_pulse || hold_expired) state_d = ST_INIT;
      default:   state_d = ST_INIT;
    endcase
  end

  // Output decode from next state, registered so it lines up with state_q.
  always_comb begin
    ctrl_d = ctrl_decode(state_d);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) ctrl_q <= CTRL_RESET;
    else       ctrl_q <= ctrl_d;
  end

  assign R1      = ctrl_q.r1;
  assign R2      = ctrl_q.r2;
  assign E1      = ctrl_q.e1;
  assign E2      = ctrl_q.e2;
  assign E3      = ctrl_q.e3;
  assign E4      = ctrl_q.e4;
  assign SEL     = ctrl_q.sel;
  assign state_o = state_q;

endmodule

// File: tb/tb_genius_control_fsm.sv
// Scoreboard bench for genius_control_fsm: stimulus pushes the expected state
// per cycle, a monitor pops and checks state_o and the control outputs.
module tb_genius_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0, end_FPGA = 1'b0, end_User = 1'b0, end_time = 1'b0;
  logic       win = 1'b0, match = 1'b0;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  logic [2:0] exp_q[$];
  int         tag_q[$];

  always #5 clk = ~clk;

  genius_control_fsm #(.P_HOLD_CYCLES(20), .P_HOLD_W(32)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .enter    (enter),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .state_o  (state_o)
  );

  // Expected {R1,R2,E1,E2,E3,E4,SEL} for each state, from the output table.
  function automatic logic [6:0] exp_ctrl(input logic [2:0] st);
    case (st)
      3'd0:    return 7'b1100001;
      3'd1:    return 7'b0010001;
      3'd2:    return 7'b0000101;
      3'd3:    return 7'b0001001;
      3'd4:    return 7'b0000001;
      3'd5:    return 7'b0100011;
      3'd6:    return 7'b0100001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic step(input bit rs, input bit en, input bit ef, input bit eu,
                      input bit et, input bit w, input bit m, input logic [2:0] exp_st);
    @(negedge clk);
    reset = rs; enter = en; end_FPGA = ef; end_User = eu; end_time = et; win = w; match = m;
    step_no++;
    exp_q.push_back(exp_st);
    tag_q.push_back(step_no);
  endtask

  task automatic idle(input logic [2:0] exp_st);
    step(0, 0, 0, 0, 0, 0, 0, exp_st);
  endtask

  // Monitor: compare once per cycle, after the edge has settled.
  initial begin
    logic [2:0] e;
    logic [6:0] got;
    int         t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {R1, R2, E1, E2, E3, E4, SEL};
        n_tests++;
        if (state_o !== e) begin
          n_fail++;
          $display("FAIL state step%0d: got %0d expected %0d", t, state_o, e);
        end
        n_tests++;
        if (got !== exp_ctrl(e)) begin
          n_fail++;
          $display("FAIL ctrl step%0d: got %b expected %b (R1 R2 E1 E2 E3 E4 SEL)", t, got, exp_ctrl(e));
        end
        $display("[TB] step%0d state=%0d ctrl=%b", t, state_o, got);
      end
    end
  end

  initial begin
    // Reset held, then released into SETUP
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 3'd0);
    for (int i = 0; i < 5; i++) idle(3'd1);
    // Held enter gives exactly one SETUP->SEQ
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 0, 3'd2);
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 0, 0, 1, 0, 0, 0, 3'd4);
    step(0, 0, 0, 0, 0, 0, 1, 3'd5);
    idle(3'd2);
    step(0, 0, 0, 1, 0, 0, 0, 3'd2);          // end_User ignored in SEQ
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 1, 0, 0, 0, 1, 1, 3'd3);          // enter/win/match ignored in PLAY
    // Timeout beats simultaneous end_User
`ifdef GENIUS_RETRY_EN
    step(0, 0, 0, 1, 1, 0, 0, 3'd6);
    idle(3'd2);
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 0, 0, 1, 0, 0, 0, 3'd4);
    step(0, 0, 0, 0, 0, 0, 0, 3'd7);          // second failure in round
`else
    step(0, 0, 0, 1, 1, 0, 0, 3'd7);
`endif
    // Auto-return after exactly 20 RESULT cycles
    for (int i = 0; i < 19; i++) idle(3'd7);
    idle(3'd0);
    idle(3'd1);
    // Win path, enter in RESULT, held enter does not re-trigger SETUP
    step(0, 1, 0, 0, 0, 0, 0, 3'd2);
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 0, 0, 1, 0, 0, 0, 3'd4);
    step(0, 0, 0, 0, 0, 1, 1, 3'd7);
    step(0, 1, 0, 0, 0, 0, 0, 3'd0);
    step(0, 1, 0, 0, 0, 0, 0, 3'd1);
    step(0, 1, 0, 0, 0, 0, 0, 3'd1);
    idle(3'd1);
    step(0, 1, 0, 0, 0, 0, 0, 3'd2);
`ifdef GENIUS_RETRY_EN
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 0, 0, 1, 0, 0, 0, 3'd4);
    step(0, 0, 0, 0, 0, 0, 0, 3'd6);
    idle(3'd2);
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 0, 0, 1, 0, 0, 0, 3'd4);
    step(0, 0, 0, 0, 0, 0, 1, 3'd5);
    idle(3'd2);
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 0, 0, 1, 0, 0, 0, 3'd4);
    step(0, 0, 0, 0, 0, 0, 0, 3'd6);          // retry available again after NEXT
    idle(3'd2);
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
`else
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
    step(0, 0, 0, 1, 0, 0, 0, 3'd4);
    step(0, 0, 0, 0, 0, 1, 0, 3'd7);          // mismatch -> RESULT
    step(0, 1, 0, 0, 0, 0, 0, 3'd0);
    idle(3'd1);
    step(0, 1, 0, 0, 0, 0, 0, 3'd2);
    step(0, 0, 1, 0, 0, 0, 0, 3'd3);
`endif
    // Reset mid-round
    step(1, 0, 0, 0, 0, 0, 0, 3'd0);
    step(1, 0, 0, 0, 0, 0, 0, 3'd0);
    idle(3'd1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
